otter_hazard_ctrl: RTL and testbench



---
 rtl/otter_pipe_pkg.sv | 16 +
 rtl/otter_hazard_ctrl_if.sv | 49 ++++
 rtl/otter_fwd_unit.sv | 26 ++
 rtl/otter_hazard_ctrl.sv | 167 ++++++++++++++++
 tb/tb_otter_hazard_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/otter_pipe_pkg.sv
// Shared types and constants for the OTTER pipeline sequencing controller.
package otter_pipe_pkg;

  typedef enum logic [2:0] {
    INIT   = 3'd0,
    RUN    = 3'd1,
    LSTALL = 3'd2,
    DRAIN  = 3'd3,
    TAKE   = 3'd4
  } ctrl_state_t;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

endpackage

// File: rtl/otter_hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle; master is the datapath, slave is the controller.
interface otter_hazard_ctrl_if #(
  parameter int RA_W = 5
);

  logic [RA_W-1:0] DC_RS1;
  logic [RA_W-1:0] DC_RS2;
  logic            DC_USES_RS1;
  logic            DC_USES_RS2;
  logic [RA_W-1:0] EX_RS1;
  logic [RA_W-1:0] EX_RS2;
  logic [RA_W-1:0] EX_RD;
  logic            EX_REGWRITE;
  logic            EX_MEMRDEN2;
  logic            EX_VALID;
  logic [1:0]      EX_PCSOURCE;
  logic [RA_W-1:0] MEM_RD;
  logic            MEM_REGWRITE;
  logic            MEM_MEMRDEN2;
  logic [RA_W-1:0] WB_RD;
  logic            WB_REGWRITE;
  logic            INTR;

  logic            PC_WRITE;
  logic            FD_WRITE;
  logic            FD_FLUSH;
  logic            DE_FLUSH;
  logic [1:0]      FWD_A_SEL;
  logic [1:0]      FWD_B_SEL;
  logic            INTR_TAKE;
  logic [2:0]      CTRL_STATE;

  modport master (
    output DC_RS1, DC_RS2, DC_USES_RS1, DC_USES_RS2,
    output EX_RS1, EX_RS2, EX_RD, EX_REGWRITE, EX_MEMRDEN2, EX_VALID, EX_PCSOURCE,
    output MEM_RD, MEM_REGWRITE, MEM_MEMRDEN2, WB_RD, WB_REGWRITE, INTR,
    input  PC_WRITE, FD_WRITE, FD_FLUSH, DE_FLUSH,
    input  FWD_A_SEL, FWD_B_SEL, INTR_TAKE, CTRL_STATE
  );

  modport slave (
    input  DC_RS1, DC_RS2, DC_USES_RS1, DC_USES_RS2,
    input  EX_RS1, EX_RS2, EX_RD, EX_REGWRITE, EX_MEMRDEN2, EX_VALID, EX_PCSOURCE,
    input  MEM_RD, MEM_REGWRITE, MEM_MEMRDEN2, WB_RD, WB_REGWRITE, INTR,
    output PC_WRITE, FD_WRITE, FD_FLUSH, DE_FLUSH,
    output FWD_A_SEL, FWD_B_SEL, INTR_TAKE, CTRL_STATE
  );

endinterface

// File: rtl/otter_fwd_unit.sv
// Combinational EX operand forwarding select for one source register.
module otter_fwd_unit
  import otter_pipe_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] rs,
  input  logic [RA_W-1:0] memRd,
  input  logic            memRegWrite,
  input  logic            memMemRdEn2,
  input  logic [RA_W-1:0] wbRd,
  input  logic            wbRegWrite,
  output logic [1:0]      fwdSel
);

  // A load in MEM has no data yet, so it is never a forwarding source here.
  always_comb begin
    fwdSel = FWD_RF;
    if (memRegWrite && !memMemRdEn2 && (memRd != '0) && (memRd == rs)) begin
      fwdSel = FWD_MEM;
    end else if (wbRegWrite && (wbRd != '0) && (wbRd == rs)) begin
      fwdSel = FWD_WB;
    end
  end

endmodule

// File: rtl/otter_hazard_ctrl.sv
// OTTER 5-stage hazard/sequencing controller: load-use stalls, redirects, forwarding, interrupt drain.
// Build option OTTER_HAZ_PERF_EN adds saturating STALL_CNT / FLUSH_CNT outputs.
module otter_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int RA_W         = 5
) (
  input logic CLK,
  input logic RST,
  otter_hazard_ctrl_if.slave hz
`ifdef OTTER_HAZ_PERF_EN
  ,
  output logic [31:0] STALL_CNT,
  output logic [31:0] FLUSH_CNT
`endif
);

  import otter_pipe_pkg::*;

  localparam logic [2:0] DrainLoad = 3'(DRAIN_CYCLES);

  ctrl_state_t state;
  ctrl_state_t nextState;
  logic [2:0]  drainCnt;
  logic [2:0]  nextCnt;
  logic        intrTakeQ;
  logic        loadUse;
  logic        redirect;
  logic        pcWrite;
  logic        fdWrite;
  logic        fdFlush;
  logic        deFlush;
  logic [1:0]  fwdA;
  logic [1:0]  fwdB;

  assign loadUse = hz.EX_MEMRDEN2 & hz.EX_REGWRITE & (hz.EX_RD != '0) &
                   ((hz.DC_USES_RS1 & (hz.DC_RS1 == hz.EX_RD)) |
                    (hz.DC_USES_RS2 & (hz.DC_RS2 == hz.EX_RD)));
  assign redirect = hz.EX_VALID & (hz.EX_PCSOURCE != 2'd0);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= INIT;
      drainCnt  <= '0;
      intrTakeQ <= 1'b0;
    end else begin
      state     <= nextState;
      drainCnt  <= nextCnt;
      intrTakeQ <= (nextState == TAKE);
    end
  end

  // Redirect outranks load-use, which outranks interrupt acceptance.
  always_comb begin
    nextState = state;
    nextCnt   = drainCnt;
    case (state)
      INIT:   nextState = RUN;
      RUN: begin
        if (redirect) begin
          nextState = RUN;
        end else if (loadUse) begin
          nextState = LSTALL;
        end else if (hz.INTR) begin
          nextState = DRAIN;
          nextCnt   = DrainLoad;
        end
      end
      LSTALL: nextState = RUN;
      DRAIN: begin
        nextCnt = drainCnt - 3'd1;
        if (drainCnt <= 3'd1) begin
          nextState = TAKE;
        end
      end
      TAKE:    nextState = RUN;
      default: nextState = INIT;
    endcase
  end

  always_comb begin
    pcWrite = 1'b1;
    fdWrite = 1'b1;
    fdFlush = 1'b0;
    deFlush = 1'b0;
    case (state)
      RUN, LSTALL: begin
        if (redirect) begin
          fdWrite = 1'b0;
          fdFlush = 1'b1;
          deFlush = 1'b1;
        end else if (loadUse && (state == RUN)) begin
          pcWrite = 1'b0;
          fdWrite = 1'b0;
          deFlush = 1'b1;
        end
      end
      DRAIN: begin
        pcWrite = redirect;
        fdWrite = 1'b0;
        fdFlush = redirect;
        deFlush = 1'b1;
      end
      default: begin
        fdWrite = 1'b0;
        fdFlush = 1'b1;
        deFlush = 1'b1;
      end
    endcase
    // Hold the front end frozen and bubbled for as long as reset is asserted.
    if (!RST) begin
      pcWrite = 1'b0;
      fdWrite = 1'b0;
      fdFlush = 1'b1;
      deFlush = 1'b1;
    end
  end

  otter_fwd_unit #(.RA_W(RA_W)) fwdUnitA (
    .rs          (hz.EX_RS1),
    .memRd       (hz.MEM_RD),
    .memRegWrite (hz.MEM_REGWRITE),
    .memMemRdEn2 (hz.MEM_MEMRDEN2),
    .wbRd        (hz.WB_RD),
    .wbRegWrite  (hz.WB_REGWRITE),
    .fwdSel      (fwdA)
  );

  otter_fwd_unit #(.RA_W(RA_W)) fwdUnitB (
    .rs          (hz.EX_RS2),
    .memRd       (hz.MEM_RD),
    .memRegWrite (hz.MEM_REGWRITE),
    .memMemRdEn2 (hz.MEM_MEMRDEN2),
    .wbRd        (hz.WB_RD),
    .wbRegWrite  (hz.WB_REGWRITE),
    .fwdSel      (fwdB)
  );

  assign hz.PC_WRITE   = pcWrite;
  assign hz.FD_WRITE   = fdWrite;
  assign hz.FD_FLUSH   = fdFlush;
  assign hz.DE_FLUSH   = deFlush;
  assign hz.FWD_A_SEL  = RST ? fwdA : FWD_RF;
  assign hz.FWD_B_SEL  = RST ? fwdB : FWD_RF;
  assign hz.INTR_TAKE  = intrTakeQ;
  assign hz.CTRL_STATE = state;

`ifdef OTTER_HAZ_PERF_EN
  logic countable;
  logic stallEvt;
  logic flushEvt;

  assign countable = (state == RUN) || (state == LSTALL) || (state == DRAIN);
  assign stallEvt  = countable & ~pcWrite;
  assign flushEvt  = countable & redirect;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      STALL_CNT <= '0;
      FLUSH_CNT <= '0;
    end else begin
      if (stallEvt && (STALL_CNT != '1)) STALL_CNT <= STALL_CNT + 32'd1;
      if (flushEvt && (FLUSH_CNT != '1)) FLUSH_CNT <= FLUSH_CNT + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_otter_hazard_ctrl.sv
// Directed bench for otter_hazard_ctrl with a cycle-level behavioural model checked every cycle.
module tb_otter_hazard_ctrl;

  localparam int RA_W  = 5;
  localparam int DRAIN = 3;

  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  otter_hazard_ctrl_if #(.RA_W(RA_W)) hz ();

`ifdef OTTER_HAZ_PERF_EN
  logic [31:0] stallCnt;
  logic [31:0] flushCnt;
`endif

  otter_hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .RA_W(RA_W)) dut (
    .CLK (clk),
    .RST (rstN),
    .hz  (hz)
`ifdef OTTER_HAZ_PERF_EN
    ,
    .STALL_CNT (stallCnt),
    .FLUSH_CNT (flushCnt)
`endif
  );

  typedef struct {
    logic       rstN;
    logic [4:0] dcRs1, dcRs2;
    logic       dcUse1, dcUse2;
    logic [4:0] exRs1, exRs2, exRd;
    logic       exRegWrite, exLoad, exValid;
    logic [1:0] exPcSrc;
    logic [4:0] memRd;
    logic       memRegWrite, memLoad;
    logic [4:0] wbRd;
    logic       wbRegWrite;
    logic       intr;
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Every register distinct: no hazard, no forwarding, no redirect.
  function automatic vec_t quiet();
    vec_t v;
    v.rstN = 1'b1;
    v.dcRs1 = 5'd1;  v.dcRs2 = 5'd2;  v.dcUse1 = 1'b1; v.dcUse2 = 1'b1;
    v.exRs1 = 5'd10; v.exRs2 = 5'd11; v.exRd = 5'd3;
    v.exRegWrite = 1'b1; v.exLoad = 1'b0; v.exValid = 1'b1; v.exPcSrc = 2'd0;
    v.memRd = 5'd12; v.memRegWrite = 1'b1; v.memLoad = 1'b0;
    v.wbRd = 5'd13;  v.wbRegWrite = 1'b1;
    v.intr = 1'b0;
    return v;
  endfunction

  task automatic driveVec(input vec_t v);
    rstN            = v.rstN;
    hz.DC_RS1       = v.dcRs1;
    hz.DC_RS2       = v.dcRs2;
    hz.DC_USES_RS1  = v.dcUse1;
    hz.DC_USES_RS2  = v.dcUse2;
    hz.EX_RS1       = v.exRs1;
    hz.EX_RS2       = v.exRs2;
    hz.EX_RD        = v.exRd;
    hz.EX_REGWRITE  = v.exRegWrite;
    hz.EX_MEMRDEN2  = v.exLoad;
    hz.EX_VALID     = v.exValid;
    hz.EX_PCSOURCE  = v.exPcSrc;
    hz.MEM_RD       = v.memRd;
    hz.MEM_REGWRITE = v.memRegWrite;
    hz.MEM_MEMRDEN2 = v.memLoad;
    hz.WB_RD        = v.wbRd;
    hz.WB_REGWRITE  = v.wbRegWrite;
    hz.INTR         = v.intr;
  endtask

  // One cycle: drive just after the edge, return just after the falling edge for literal checks.
  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    driveVec(v);
    @(negedge clk);
    #1;
  endtask

  // Model: where the controller is, expressed as pending obligations rather than a state machine.
  bit mInit        = 1'b1;
  bit mStallFollow = 1'b0;
  int mDrainLeft   = 0;
  bit mTakeDue     = 1'b0;
  int mStalls      = 0;
  int mFlushes     = 0;

  function automatic logic [1:0] fwdModel(input logic [4:0] rs);
    if (rs == 5'd0) return 2'd0;
    if (hz.MEM_REGWRITE && !hz.MEM_MEMRDEN2 && hz.MEM_RD == rs) return 2'd1;
    if (hz.WB_REGWRITE && hz.WB_RD == rs) return 2'd2;
    return 2'd0;
  endfunction

  always @(negedge clk) begin : compareProc
    logic eP, eF, eFf, eDf, eT;
    logic [1:0] eA, eB;
    int eS;
    bit haz, redir, countable;
    haz = 1'b0; redir = 1'b0; countable = 1'b0;
    if (rstN !== 1'b1) begin
      eP = 0; eF = 0; eFf = 1; eDf = 1; eT = 0; eA = 0; eB = 0; eS = 0;
    end else begin
      haz = hz.EX_MEMRDEN2 && hz.EX_REGWRITE && hz.EX_RD != 0 &&
            ((hz.DC_USES_RS1 && hz.DC_RS1 == hz.EX_RD) || (hz.DC_USES_RS2 && hz.DC_RS2 == hz.EX_RD));
      redir = hz.EX_VALID && hz.EX_PCSOURCE != 0;
      eA = fwdModel(hz.EX_RS1);
      eB = fwdModel(hz.EX_RS2);
      eT = mTakeDue;
      eS = mInit ? 0 : mTakeDue ? 4 : (mDrainLeft > 0) ? 3 : mStallFollow ? 2 : 1;
      countable = (eS >= 1 && eS <= 3);
      if (mInit || mTakeDue) begin
        eP = 1; eF = 0; eFf = 1; eDf = 1;
      end else if (mDrainLeft > 0) begin
        eP = redir; eF = 0; eFf = redir; eDf = 1;
      end else if (redir) begin
        eP = 1; eF = 0; eFf = 1; eDf = 1;
      end else if (haz && !mStallFollow) begin
        eP = 0; eF = 0; eFf = 0; eDf = 1;
      end else begin
        eP = 1; eF = 1; eFf = 0; eDf = 0;
      end
    end
    checkOutput("pcWrite",   32'(hz.PC_WRITE),   32'(eP));
    checkOutput("fdWrite",   32'(hz.FD_WRITE),   32'(eF));
    checkOutput("fdFlush",   32'(hz.FD_FLUSH),   32'(eFf));
    checkOutput("deFlush",   32'(hz.DE_FLUSH),   32'(eDf));
    checkOutput("fwdA",      32'(hz.FWD_A_SEL),  32'(eA));
    checkOutput("fwdB",      32'(hz.FWD_B_SEL),  32'(eB));
    checkOutput("intrTake",  32'(hz.INTR_TAKE),  32'(eT));
    checkOutput("ctrlState", 32'(hz.CTRL_STATE), 32'(eS));
`ifdef OTTER_HAZ_PERF_EN
    checkOutput("stallCnt", stallCnt, (rstN !== 1'b1) ? 32'd0 : 32'(mStalls));
    checkOutput("flushCnt", flushCnt, (rstN !== 1'b1) ? 32'd0 : 32'(mFlushes));
`endif
    if (rstN !== 1'b1) begin
      mInit = 1; mStallFollow = 0; mDrainLeft = 0; mTakeDue = 0; mStalls = 0; mFlushes = 0;
    end else begin
      if (countable && !eP) mStalls++;
      if (countable && redir) mFlushes++;
      if (mInit) begin
        mInit = 0;
      end else if (mTakeDue) begin
        mTakeDue = 0;
      end else if (mDrainLeft > 0) begin
        mDrainLeft--;
        if (mDrainLeft == 0) mTakeDue = 1;
      end else if (redir) begin
        mStallFollow = 0;
      end else if (haz && !mStallFollow) begin
        mStallFollow = 1;
      end else begin
        if (!mStallFollow && hz.INTR) mDrainLeft = DRAIN;
        mStallFollow = 0;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    vec_t v;
    v = quiet(); v.rstN = 1'b0;
    driveVec(v);
    applyStimulus(v);
    checkOutput("rstPcWrite", 32'(hz.PC_WRITE), 32'd0);
    checkOutput("rstFdFlush", 32'(hz.FD_FLUSH), 32'd1);

    // First cycle after release is the INIT flush cycle.
    applyStimulus(quiet());
    checkOutput("initState",   32'(hz.CTRL_STATE), 32'd0);
    checkOutput("initFdFlush", 32'(hz.FD_FLUSH),   32'd1);
    checkOutput("initDeFlush", 32'(hz.DE_FLUSH),   32'd1);
    checkOutput("initPcWrite", 32'(hz.PC_WRITE),   32'd1);
    applyStimulus(quiet());
    checkOutput("runState",   32'(hz.CTRL_STATE), 32'd1);
    checkOutput("runPcWrite", 32'(hz.PC_WRITE),   32'd1);
    checkOutput("runFdFlush", 32'(hz.FD_FLUSH),   32'd0);

    v = quiet(); v.exLoad = 1; v.exRd = 5'd5; v.dcRs1 = 5'd5;
    applyStimulus(v);
    checkOutput("luPcWrite", 32'(hz.PC_WRITE), 32'd0);
    checkOutput("luFdWrite", 32'(hz.FD_WRITE), 32'd0);
    checkOutput("luDeFlush", 32'(hz.DE_FLUSH), 32'd1);
    // Hazard still visible in LSTALL must not stall again.
    v.exRs1 = 5'd5; v.memRd = 5'd5; v.memLoad = 1; v.wbRd = 5'd5;
    applyStimulus(v);
    checkOutput("lstallState", 32'(hz.CTRL_STATE), 32'd2);
    checkOutput("lstallPc",    32'(hz.PC_WRITE),   32'd1);
    checkOutput("fwdAfromWb",  32'(hz.FWD_A_SEL),  32'd2);

    v = quiet(); v.memRd = 5'd7; v.wbRd = 5'd7; v.exRs2 = 5'd7;
    applyStimulus(v);
    checkOutput("fwdBmemWins", 32'(hz.FWD_B_SEL), 32'd1);
    v.memRd = 5'd0; v.wbRd = 5'd0; v.exRs2 = 5'd0;
    applyStimulus(v);
    checkOutput("fwdBx0", 32'(hz.FWD_B_SEL), 32'd0);
    v = quiet(); v.exRs1 = 5'd9; v.memRd = 5'd9; v.memRegWrite = 0; v.wbRd = 5'd9;
    applyStimulus(v);
    checkOutput("fwdAnoMemWr", 32'(hz.FWD_A_SEL), 32'd2);
    v = quiet(); v.exRs1 = 5'd12; v.exRs2 = 5'd12;
    applyStimulus(v);
    checkOutput("fwdAboth", 32'(hz.FWD_A_SEL), 32'd1);
    checkOutput("fwdBboth", 32'(hz.FWD_B_SEL), 32'd1);

    v = quiet(); v.exLoad = 1; v.exRd = 5'd5; v.dcRs2 = 5'd5; v.exPcSrc = 2'd2;
    applyStimulus(v);
    checkOutput("redirFdFlush", 32'(hz.FD_FLUSH), 32'd1);
    checkOutput("redirDeFlush", 32'(hz.DE_FLUSH), 32'd1);
    checkOutput("redirPc",      32'(hz.PC_WRITE), 32'd1);
    applyStimulus(quiet());
    checkOutput("redirNoStall", 32'(hz.CTRL_STATE), 32'd1);

    v = quiet(); v.exLoad = 1; v.exRd = 5'd6; v.dcRs1 = 5'd6;
    applyStimulus(v);
    v = quiet(); v.exPcSrc = 2'd1;
    applyStimulus(v);
    checkOutput("lstallRedirFf", 32'(hz.FD_FLUSH), 32'd1);
    v.exValid = 0;
    applyStimulus(v);
    checkOutput("bubbleNoRedir", 32'(hz.FD_FLUSH), 32'd0);
    v = quiet(); v.exLoad = 1; v.exRd = 5'd0; v.dcRs1 = 5'd0;
    applyStimulus(v);
    checkOutput("loadX0NoStall", 32'(hz.PC_WRITE), 32'd1);
    v = quiet(); v.exLoad = 1; v.exRd = 5'd8; v.dcRs1 = 5'd8; v.dcUse1 = 0;
    applyStimulus(v);
    checkOutput("unusedRsNoStall", 32'(hz.PC_WRITE), 32'd1);

    // One-cycle interrupt pulse: three drain bubbles, then the take pulse.
    v = quiet(); v.intr = 1;
    applyStimulus(v);
    for (int i = 0; i < DRAIN; i++) begin
      applyStimulus(quiet());
      checkOutput("drainPc", 32'(hz.PC_WRITE), 32'd0);
    end
    applyStimulus(quiet());
    checkOutput("takePulse", 32'(hz.INTR_TAKE),  32'd1);
    checkOutput("takeState", 32'(hz.CTRL_STATE), 32'd4);
    applyStimulus(quiet());
    checkOutput("takeEnds", 32'(hz.INTR_TAKE), 32'd0);

    // Interrupt deferred by a load-use stall, redirect inside drain, level held through take.
    v = quiet(); v.exLoad = 1; v.exRd = 5'd4; v.dcRs1 = 5'd4; v.intr = 1;
    applyStimulus(v);
    v = quiet(); v.intr = 1;
    applyStimulus(v);
    applyStimulus(v);
    applyStimulus(v);
    v.exPcSrc = 2'd3;
    applyStimulus(v);
    checkOutput("drainRedirPc",    32'(hz.PC_WRITE),   32'd1);
    checkOutput("drainRedirState", 32'(hz.CTRL_STATE), 32'd3);
    v = quiet(); v.intr = 1;
    applyStimulus(v);
    applyStimulus(v);
    applyStimulus(v);
    v.intr = 0;
    applyStimulus(v);
    applyStimulus(v);
    v = quiet(); v.rstN = 0;
    applyStimulus(v);
    checkOutput("rstDrainState", 32'(hz.CTRL_STATE), 32'd0);
    checkOutput("rstDrainTake",  32'(hz.INTR_TAKE),  32'd0);
    for (int i = 0; i < 6; i++) applyStimulus(quiet());
    checkOutput("noLateTake", 32'(hz.INTR_TAKE), 32'd0);

`ifdef OTTER_HAZ_PERF_EN
    v = quiet(); v.rstN = 0;
    applyStimulus(v);
    applyStimulus(quiet());
    applyStimulus(quiet());
    for (int i = 0; i < 2; i++) begin
      v = quiet(); v.exLoad = 1; v.exRd = 5'd5; v.dcRs1 = 5'd5;
      applyStimulus(v);
      applyStimulus(quiet());
    end
    v = quiet(); v.exPcSrc = 2'd1;
    for (int i = 0; i < 3; i++) applyStimulus(v);
    applyStimulus(quiet());
    checkOutput("perfStalls",  stallCnt, 32'd2);
    checkOutput("perfFlushes", flushCnt, 32'd3);
`endif

    applyStimulus(quiet());
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
